vpu_traffic_gen: RTL and testbench

//  Synthesizable stimulus/response engine for VPU_TOP, for on-chip self-test and fast regression.

---
 rtl/vpu_traffic_gen_pkg.sv | 30 +++
 rtl/vpu_tg_lfsr_src.sv | 59 +++++
 rtl/vpu_traffic_gen.sv | 164 ++++++++++++++++
 tb/tb_vpu_traffic_gen.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/vpu_traffic_gen_pkg.sv
// Shared types, constants and helpers for the VPU traffic generator.
package vpu_traffic_gen_pkg;

  typedef enum logic [1:0] {
    TG_IDLE,
    TG_ISSUE,
    TG_DRAIN,
    TG_DONE
  } tg_state_t;

  localparam logic [31:0] TG_LFSR_POLY = 32'h80200003;
  localparam logic [31:0] TG_MISR_POLY = 32'h04C11DB7;
  localparam int          TG_LANE_ROT  = 7;

  function automatic logic [31:0] tg_rotl(
    input logic [31:0] x,
    input logic [4:0]  n
  );
    logic [63:0] t;
    t = {x, x} << n;
    return t[63:32];
  endfunction

  function automatic logic [31:0] tg_lfsr_step(
    input logic [31:0] l
  );
    return (l >> 1) ^ (l[0] ? TG_LFSR_POLY : 32'h0);
  endfunction

endpackage

// File: rtl/vpu_tg_lfsr_src.sv
// One pseudo-random operand source: LFSR, lane expansion, mask and
// a fixed-latency read pipeline whose output holds between reads.
module vpu_tg_lfsr_src
  import vpu_traffic_gen_pkg::*;
#(
  parameter int          LANES  = 32,
  parameter int          ELEM_W = 16,
  parameter int          RD_LAT = 1,
  parameter logic [31:0] SEED   = 32'hACE11234
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    i_reload,
  input  logic [ELEM_W-1:0]       i_mask,
  input  logic                    i_rd_en,
  output logic                    o_rvalid,
  output logic [LANES*ELEM_W-1:0] o_rdata
);

  localparam int RW = LANES * ELEM_W;

  logic [31:0]       r_lfsr;
  logic [RD_LAT-1:0] r_vld;
  logic [RW-1:0]     r_dat [RD_LAT];
  logic [RW-1:0]     w_row;

  always_comb begin
    logic [31:0] t;
    w_row = '0;
    for (int k = 0; k < LANES; k++) begin
      t = tg_rotl(r_lfsr, 5'((TG_LANE_ROT * k) % 32));
      w_row[k*ELEM_W +: ELEM_W] = t[ELEM_W-1:0] & i_mask;
    end
  end

  // Data stages only load behind a valid, so the last stage holds.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_lfsr <= SEED;
      r_vld  <= '0;
      for (int i = 0; i < RD_LAT; i++) r_dat[i] <= '0;
    end else begin
      if (i_reload)
        r_lfsr <= SEED;
      else if (i_rd_en)
        r_lfsr <= tg_lfsr_step(r_lfsr);
      r_vld[0] <= i_rd_en;
      if (i_rd_en) r_dat[0] <= w_row;
      for (int i = 1; i < RD_LAT; i++) begin
        r_vld[i] <= r_vld[i-1];
        if (r_vld[i-1]) r_dat[i] <= r_dat[i-1];
      end
    end
  end

  assign o_rvalid = r_vld[RD_LAT-1];
  assign o_rdata  = r_dat[RD_LAT-1];

endmodule

// File: rtl/vpu_traffic_gen.sv
// VPU self-test traffic generator: credit-bounded request issue,
// pseudo-random operand sources and a MISR over result writes.
module vpu_traffic_gen
  import vpu_traffic_gen_pkg::*;
#(
  parameter int          NUM_SRC  = 3,
  parameter int          LANES    = 32,
  parameter int          ELEM_W   = 16,
  parameter int          OPCODE_W = 5,
  parameter int          ITER_W   = 16,
  parameter int          MAX_OUT  = 4,
  parameter int          RD_LAT   = 1,
  parameter logic [31:0] SEED     = 32'hACE11234
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            start,
  input  logic [OPCODE_W-1:0]             cfg_opcode,
  input  logic [ITER_W-1:0]               cfg_iter,
  input  logic [ELEM_W-1:0]               cfg_mask,
  output logic                            busy,
  output logic                            done,
  output logic                            req_valid,
  output logic [OPCODE_W-1:0]             req_opcode,
  input  logic                            req_ready,
  input  logic [NUM_SRC-1:0]              src_rd_en,
  output logic [NUM_SRC-1:0]              src_rvalid,
  output logic [NUM_SRC*LANES*ELEM_W-1:0] src_rdata,
  input  logic                            dst_wr_en,
  input  logic [LANES*ELEM_W-1:0]         dst_wdata,
  output logic [31:0]                     signature,
  output logic [ITER_W-1:0]               req_cnt,
  output logic [ITER_W-1:0]               wr_cnt,
  output logic                            err_extra_wr,
  output logic                            err_stray_rd
);

  localparam int RW = LANES * ELEM_W;
  localparam int NW = RW / 32;

  tg_state_t           r_state;
  logic                r_busy, r_done, r_req_valid;
  logic [OPCODE_W-1:0] r_req_op;
  logic [ITER_W-1:0]   r_iter, r_req_cnt, r_wr_cnt;
  logic [ELEM_W-1:0]   r_mask;
  logic [31:0]         r_sig;
  logic                r_err_extra, r_err_stray;

  logic              w_start, w_hs, w_wr_inc;
  logic [ITER_W-1:0] w_req_nxt, w_wr_nxt, w_out, w_out_nxt;
  logic [31:0]       w_fold;

  always_comb begin
    w_start   = (r_state == TG_IDLE) && start;
    w_hs      = r_req_valid && req_ready;
    w_wr_inc  = dst_wr_en && (r_wr_cnt != '1);
    w_req_nxt = r_req_cnt + ITER_W'(w_hs);
    w_wr_nxt  = r_wr_cnt + ITER_W'(w_wr_inc);
    w_out     = r_req_cnt - r_wr_cnt;
    w_out_nxt = w_req_nxt - w_wr_nxt;
    w_fold    = '0;
    for (int w = 0; w < NW; w++) w_fold ^= dst_wdata[w*32 +: 32];
  end

  // req_valid is registered from next-cycle counters so credit is exact.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= TG_IDLE;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_req_valid <= 1'b0;
      r_req_op    <= '0;
      r_iter      <= '0;
      r_mask      <= '0;
    end else begin
      unique case (r_state)
        TG_IDLE: if (start) begin
          r_iter <= cfg_iter;
          r_mask <= cfg_mask;
          if (cfg_iter == '0) begin
            r_state <= TG_DONE;
            r_done  <= 1'b1;
          end else begin
            r_state     <= TG_ISSUE;
            r_busy      <= 1'b1;
            r_req_valid <= 1'b1;
            r_req_op    <= cfg_opcode;
          end
        end
        TG_ISSUE: begin
          if (w_hs && w_req_nxt == r_iter) begin
            r_state     <= TG_DRAIN;
            r_req_valid <= 1'b0;
          end else begin
            r_req_valid <= w_out_nxt < ITER_W'(MAX_OUT);
          end
        end
        TG_DRAIN: if (r_wr_cnt == r_iter) begin
          r_state  <= TG_DONE;
          r_busy   <= 1'b0;
          r_req_op <= '0;
          r_done   <= 1'b1;
        end
        TG_DONE: begin
          r_state <= TG_IDLE;
          r_done  <= 1'b0;
        end
        default: r_state <= TG_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_req_cnt   <= '0;
      r_wr_cnt    <= '0;
      r_sig       <= '0;
      r_err_extra <= 1'b0;
      r_err_stray <= 1'b0;
    end else if (w_start) begin
      r_req_cnt   <= '0;
      r_wr_cnt    <= '0;
      r_sig       <= '0;
      r_err_extra <= 1'b0;
      r_err_stray <= 1'b0;
    end else begin
      r_req_cnt <= w_req_nxt;
      r_wr_cnt  <= w_wr_nxt;
      if (dst_wr_en)
        r_sig <= {r_sig[30:0], 1'b0}
               ^ (r_sig[31] ? TG_MISR_POLY : 32'h0) ^ w_fold;
      if (dst_wr_en && w_out == '0 && !w_hs) r_err_extra <= 1'b1;
      if (|src_rd_en && !r_busy) r_err_stray <= 1'b1;
    end
  end

  for (genvar s = 0; s < NUM_SRC; s++) begin : g_src
    vpu_tg_lfsr_src #(
      .LANES  (LANES),
      .ELEM_W (ELEM_W),
      .RD_LAT (RD_LAT),
      .SEED   (SEED ^ (32'(s) * 32'h9E3779B9))
    ) u_src (
      .clk      (clk),
      .rst      (rst),
      .i_reload (w_start),
      .i_mask   (r_mask),
      .i_rd_en  (src_rd_en[s]),
      .o_rvalid (src_rvalid[s]),
      .o_rdata  (src_rdata[s*RW +: RW])
    );
  end

  assign busy         = r_busy;
  assign done         = r_done;
  assign req_valid    = r_req_valid;
  assign req_opcode   = r_req_op;
  assign signature    = r_sig;
  assign req_cnt      = r_req_cnt;
  assign wr_cnt       = r_wr_cnt;
  assign err_extra_wr = r_err_extra;
  assign err_stray_rd = r_err_stray;

endmodule

// File: tb/tb_vpu_traffic_gen.sv
// Directed/randomized bench for vpu_traffic_gen with a behavioural
// VPU, LFSR-row and MISR reference model.
module tb_vpu_traffic_gen;

  localparam int RW = 512;
  localparam logic [31:0] SEED1 = 32'hACE11234 ^ 32'h9E3779B9;

  logic            clk = 0;
  logic            rst, start, req_ready, dst_wr_en;
  logic [4:0]      cfg_opcode;
  logic [15:0]     cfg_iter, cfg_mask;
  logic            busy, done, req_valid;
  logic [4:0]      req_opcode;
  logic [2:0]      src_rd_en, src_rvalid;
  logic [3*RW-1:0] src_rdata;
  logic [RW-1:0]   dst_wdata;
  logic [31:0]     signature;
  logic [15:0]     req_cnt, wr_cnt;
  logic            err_extra_wr, err_stray_rd;

  int nvec = 0;
  int nmis = 0;
  logic [RW-1:0] wd [16];
  logic [31:0]   m_sig, sig1;
  int            ndone, hs;
  bit            hit_abort;

  vpu_traffic_gen #(.RD_LAT(2), .MAX_OUT(4)) dut (
    .clk(clk), .rst(rst), .start(start),
    .cfg_opcode(cfg_opcode), .cfg_iter(cfg_iter), .cfg_mask(cfg_mask),
    .busy(busy), .done(done), .req_valid(req_valid),
    .req_opcode(req_opcode), .req_ready(req_ready),
    .src_rd_en(src_rd_en), .src_rvalid(src_rvalid),
    .src_rdata(src_rdata), .dst_wr_en(dst_wr_en),
    .dst_wdata(dst_wdata), .signature(signature),
    .req_cnt(req_cnt), .wr_cnt(wr_cnt),
    .err_extra_wr(err_extra_wr), .err_stray_rd(err_stray_rd)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [RW-1:0] obs,
                     input logic [RW-1:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nmis++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [RW-1:0] rnd_row();
    logic [RW-1:0] d;
    for (int w = 0; w < 16; w++) d[w*32 +: 32] = $urandom;
    return d;
  endfunction

  // Signature update computed straight from the folding rule.
  function automatic logic [31:0] misr(input logic [31:0] s,
                                       input logic [RW-1:0] d);
    logic [31:0] f = 0;
    for (int w = 0; w < 16; w++) f ^= d[w*32 +: 32];
    return {s[30:0], 1'b0} ^ (s[31] ? 32'h04C11DB7 : 32'h0) ^ f;
  endfunction

  function automatic logic [RW-1:0] exp_row(input int n,
                                            input logic [15:0] m);
    logic [31:0] l = SEED1;
    logic [31:0] t;
    logic [RW-1:0] r;
    int rot;
    for (int i = 0; i < n; i++)
      l = l[0] ? ((l >> 1) ^ 32'h80200003) : (l >> 1);
    for (int k = 0; k < 32; k++) begin
      rot = (7 * k) % 32;
      t = (rot == 0) ? l : ((l << rot) | (l >> (32 - rot)));
      r[k*16 +: 16] = t[15:0] & m;
    end
    return r;
  endfunction

  // VPU model: each accepted request is written back 3 cycles later.
  task automatic run_vpu(input int iter, input bit fresh,
                         input bit abort2);
    int due[$];
    int wi = 0;
    bit fin = 0;
    logic [31:0] s = 0;
    ndone = 0;
    hit_abort = 0;
    tick();
    cfg_iter = 16'(iter);
    cfg_opcode = 5'd17;
    cfg_mask = 16'hFFFF;
    req_ready = 1;
    start = 1;
    tick();
    start = 0;
    chk("start_clr", {err_extra_wr, err_stray_rd, req_cnt, wr_cnt,
                      signature}, '0);
    chk("req_opcode", RW'(req_opcode), RW'(17));
    for (int cyc = 0; cyc < 300 && !fin; cyc++) begin
      if (abort2 && req_cnt == 16'(iter) && wr_cnt == 16'(iter - 2)) begin
        hit_abort = 1;
        rst = 1;
        #1;
        chk("async_rst", {busy, done, req_valid, req_opcode, req_cnt,
                          wr_cnt, signature, err_extra_wr,
                          err_stray_rd, src_rvalid}, '0);
        dst_wr_en = 0;
        tick();
        tick();
        rst = 0;
        tick();
        return;
      end
      if (done) begin
        ndone++;
        fin = 1;
      end else begin
        dst_wr_en = 0;
        if (due.size() > 0 && due[0] == cyc) begin
          void'(due.pop_front());
          if (fresh) wd[wi] = rnd_row();
          dst_wdata = wd[wi];
          dst_wr_en = 1;
          s = misr(s, wd[wi]);
          wi++;
        end
        if (req_valid && req_ready) due.push_back(cyc + 3);
        tick();
      end
    end
    dst_wr_en = 0;
    m_sig = s;
    chk("run_finished", RW'(fin), RW'(1));
  endtask

  initial begin
    rst = 1; start = 0; req_ready = 0; dst_wr_en = 0;
    cfg_opcode = 0; cfg_iter = 0; cfg_mask = 0;
    src_rd_en = 0; dst_wdata = 0;
    tick(); tick(); tick();
    chk("reset_ctl", {busy, done, req_valid, req_opcode, req_cnt,
                      wr_cnt, signature, err_extra_wr,
                      err_stray_rd, src_rvalid}, '0);
    chk("reset_rdata", RW'(|src_rdata), '0);
    rst = 0;
    tick();

    // Full 7-request run with delayed write-back.
    run_vpu(7, 1, 0);
    sig1 = m_sig;
    chk("r1_done_cnt", RW'(ndone), RW'(1));
    chk("r1_req_cnt", RW'(req_cnt), RW'(7));
    chk("r1_wr_cnt", RW'(wr_cnt), RW'(7));
    chk("r1_sig", RW'(signature), RW'(sig1));
    chk("r1_err", {err_extra_wr, err_stray_rd}, '0);
    chk("r1_opc_idle", RW'(req_opcode), '0);

    // Credit limit with no write-back, then one/two writes.
    tick();
    cfg_iter = 10;
    start = 1;
    tick();
    start = 0;
    hs = 0;
    for (int i = 0; i < 10; i++) begin
      if (req_valid && req_ready) hs++;
      tick();
    end
    chk("credit_hs", RW'(hs), RW'(4));
    chk("credit_cnt", RW'(req_cnt), RW'(4));
    chk("credit_stall", RW'(req_valid), '0);
    dst_wdata = rnd_row();
    dst_wr_en = 1;
    tick();
    chk("credit_back", RW'(req_valid), RW'(1));
    chk("credit_wr", RW'(wr_cnt), RW'(1));
    tick();
    dst_wr_en = 0;
    chk("same_cyc_req", RW'(req_cnt), RW'(5));
    chk("same_cyc_wr", RW'(wr_cnt), RW'(2));
    chk("same_cyc_valid", RW'(req_valid), RW'(1));
    chk("same_cyc_err", RW'(err_extra_wr), '0);
    req_ready = 0;
    rst = 1;
    tick();
    rst = 0;
    tick();

    // Zero-iteration start: immediate done, never busy.
    cfg_iter = 0;
    cfg_mask = 16'h0007;
    start = 1;
    tick();
    start = 0;
    chk("zero_done", {done, busy, req_valid}, 3'b100);
    tick();
    chk("zero_after", {done, busy, req_valid}, 3'b000);

    // Five back-to-back reads on source 1, masked rows.
    for (int c = 0; c < 8; c++) begin
      src_rd_en = (c < 5) ? 3'b010 : 3'b000;
      tick();
      chk($sformatf("rd_valid_%0d", c), RW'(src_rvalid),
          (c >= 1 && c <= 5) ? RW'(3'b010) : '0);
      chk($sformatf("rd_data_%0d", c), src_rdata[RW +: RW],
          (c == 0) ? '0 : exp_row((c - 1 < 4) ? c - 1 : 4, 16'h0007));
    end
    chk("stray_rd", RW'(err_stray_rd), RW'(1));

    dst_wdata = rnd_row();
    dst_wr_en = 1;
    tick();
    dst_wr_en = 0;
    chk("extra_wr", RW'(err_extra_wr), RW'(1));
    tick(); tick(); tick();
    chk("extra_wr_sticky", RW'(err_extra_wr), RW'(1));

    // Abort in DRAIN, then replay the first run.
    run_vpu(7, 0, 1);
    chk("abort_hit", RW'(hit_abort), RW'(1));
    chk("abort_no_done", RW'(ndone), '0);
    run_vpu(7, 0, 0);
    chk("replay_done", RW'(ndone), RW'(1));
    chk("replay_sig", RW'(signature), RW'(sig1));
    chk("replay_cnt", {req_cnt, wr_cnt}, {16'd7, 16'd7});

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end

endmodule
